// File: rtl/paddle_adc.sv
// Paddle position reader: free-running serial ADC frame controller with clamped output.
// Define PADDLE_AVG_EN to add a 4-tap moving average ahead of the clamp.
module paddle_adc #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 16,
  parameter logic [7:0]  Y_MIN      = 8'd16,
  parameter logic [7:0]  Y_MAX      = 8'd239
) (
  input  logic       clk,
  input  logic       reset,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  input  logic       adc_dout,
  output logic [7:0] y_p_mid,
  output logic       valid
);

  // state  | meaning
  // S_IDLE | cs_n high, counting the inter-frame gap
  // S_CONV | cs_n low, 10 SCLK periods, sampling on each rising edge
  // S_DONE | cs_n high, y_p_mid loaded, valid pulse
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [7:0]  DIV_LOAD  = 8'(CLK_DIV - 1);
  localparam logic [4:0]  HALF_LAST = 5'd19;
  localparam logic [7:0]  Y_RESET   = 8'd128;

  state_t      state_q, state_d;
  logic [15:0] gap_q, gap_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  half_q, half_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        valid_q, valid_d;
  logic [7:0]  y_q, y_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  s_val;

`ifdef PADDLE_AVG_EN
  logic [7:0]  h1_q, h1_d;
  logic [7:0]  h2_q, h2_d;
  logic [7:0]  h3_q, h3_d;
  logic [9:0]  sum;
`endif

  function automatic logic [7:0] clamp_y(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v < Y_MIN) r = Y_MIN;
    else if (v > Y_MAX) r = Y_MAX;
    return r;
  endfunction

  always_comb begin
`ifdef PADDLE_AVG_EN
    sum   = {2'b00, sh_q} + {2'b00, h1_q} + {2'b00, h2_q} + {2'b00, h3_q};
    s_val = 8'(sum >> 2);
`else
    s_val = sh_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    div_d   = div_q;
    half_d  = half_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    valid_d = 1'b0;
    y_d     = y_q;
    sh_d    = sh_q;
`ifdef PADDLE_AVG_EN
    h1_d    = h1_q;
    h2_d    = h2_q;
    h3_d    = h3_q;
`endif

    case (state_q)
      S_IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_CONV;
          cs_n_d  = 1'b0;
          div_d   = DIV_LOAD;
          half_d  = '0;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end

      S_CONV: begin
        if (div_q == 8'd0) begin
          div_d = DIV_LOAD;
          if (half_q == HALF_LAST) begin
            state_d = S_DONE;
            sclk_d  = 1'b0;
            cs_n_d  = 1'b1;
            valid_d = 1'b1;
            y_d     = clamp_y(s_val);
`ifdef PADDLE_AVG_EN
            h1_d    = sh_q;
            h2_d    = h1_q;
            h3_d    = h2_q;
`endif
          end else begin
            half_d = half_q + 5'd1;
            sclk_d = ~sclk_q;
            // Null bits shift straight through; only the last 8 edges survive.
            if (!sclk_q) sh_d = {sh_q[6:0], adc_dout};
          end
        end else begin
          div_d = div_q - 8'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        gap_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        gap_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      div_q   <= '0;
      half_q  <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      valid_q <= 1'b0;
      y_q     <= Y_RESET;
      sh_q    <= '0;
`ifdef PADDLE_AVG_EN
      h1_q    <= Y_RESET;
      h2_q    <= Y_RESET;
      h3_q    <= Y_RESET;
`endif
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      div_q   <= div_d;
      half_q  <= half_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      valid_q <= valid_d;
      y_q     <= y_d;
      sh_q    <= sh_d;
`ifdef PADDLE_AVG_EN
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      h3_q    <= h3_d;
`endif
    end
  end

  assign adc_cs_n = cs_n_q;
  assign adc_sclk = sclk_q;
  assign valid    = valid_q;
  assign y_p_mid  = y_q;

endmodule

// File: tb/tb_paddle_adc.sv
// Directed bench for paddle_adc with CLK_DIV=2, GAP_CYCLES=4 and a simple serial ADC model.
module tb_paddle_adc;

  localparam int DIV = 2;
  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       adc_cs_n;
  logic       adc_sclk;
  logic       adc_dout = 1'b0;
  logic [7:0] y_p_mid;
  logic       valid;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_v = 0;

  logic [7:0] adc_word = 8'h00;
  int         edge_n = 0;
  logic       cs_prev = 1'b1;
  logic       sclk_prev = 1'b0;

  paddle_adc #(
    .CLK_DIV   (DIV),
    .GAP_CYCLES(GAP),
    .Y_MIN     (8'd16),
    .Y_MAX     (8'd239)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .adc_cs_n(adc_cs_n),
    .adc_sclk(adc_sclk),
    .adc_dout(adc_dout),
    .y_p_mid (y_p_mid),
    .valid   (valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ADC model: null bits are driven as 1 so a mis-framed capture shows up.
  always @(posedge clk) begin
    #1;
    if (cs_prev && !adc_cs_n) begin
      edge_n   = 0;
      adc_dout = 1'b1;
    end else if (!adc_cs_n && !sclk_prev && adc_sclk) begin
      edge_n++;
      if (edge_n < 2) adc_dout = 1'b1;
      else if (edge_n < 10) adc_dout = adc_word[9-edge_n];
      else adc_dout = 1'b0;
    end
    cs_prev   = adc_cs_n;
    sclk_prev = adc_sclk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Starts on a negedge sample inside the idle gap; ends on the idle sample after DONE.
  task automatic run_frame(input string tag, input logic [7:0] word, input int exp_y,
                           input bit gap_chk);
    int hi, lo, rises, first_rise, stray_v, y_moves, idle_sclk, budget;
    logic sclk_p;
    logic [7:0] y0;
    adc_word = word;
    hi = 0; lo = 0; rises = 0; first_rise = -1; stray_v = 0; y_moves = 0;
    idle_sclk = 0; budget = 0; sclk_p = 1'b0; y0 = y_p_mid;
    while (adc_cs_n && budget < 200) begin
      hi++;
      if (adc_sclk) idle_sclk++;
      if (valid) stray_v++;
      if (y_p_mid != y0) y_moves++;
      @(negedge clk); budget++;
    end
    while (!adc_cs_n && budget < 400) begin
      if (adc_sclk && !sclk_p) begin
        rises++;
        if (first_rise < 0) first_rise = lo;
      end
      sclk_p = adc_sclk;
      if (valid) stray_v++;
      if (y_p_mid != y0) y_moves++;
      lo++;
      @(negedge clk); budget++;
    end
    chk({tag, ":idle_cycles"}, hi, GAP);
    chk({tag, ":idle_sclk"}, idle_sclk, 0);
    chk({tag, ":cs_low_cycles"}, lo, 20 * DIV);
    chk({tag, ":sclk_rises"}, rises, 10);
    chk({tag, ":first_rise"}, first_rise, DIV);
    chk({tag, ":last_phase_high"}, int'(sclk_p), 1);
    chk({tag, ":stray_valid"}, stray_v, 0);
    chk({tag, ":y_hold"}, y_moves, 0);
    chk({tag, ":done_valid"}, int'(valid), 1);
    chk({tag, ":done_sclk"}, int'(adc_sclk), 0);
    chk({tag, ":y"}, int'(y_p_mid), exp_y);
    if (gap_chk) chk({tag, ":valid_spacing"}, cyc - last_v, GAP + 20 * DIV + 1);
    last_v = cyc;
    @(negedge clk);
    chk({tag, ":valid_drop"}, int'(valid), 0);
    chk({tag, ":y_after"}, int'(y_p_mid), exp_y);
  endtask

  task automatic abort_frame(input logic [7:0] word);
    int budget;
    adc_word = word;
    budget = 0;
    while (adc_cs_n && budget < 100) begin @(negedge clk); budget++; end
    while (edge_n < 5 && budget < 200) begin @(negedge clk); budget++; end
    chk("abort:reach_edge5", edge_n, 5);
    reset = 1'b0;
    @(negedge clk);
    chk("abort:cs_n", int'(adc_cs_n), 1);
    chk("abort:sclk", int'(adc_sclk), 0);
    chk("abort:y", int'(y_p_mid), 128);
    chk("abort:valid", int'(valid), 0);
    reset = 1'b1;
  endtask

`ifdef PADDLE_AVG_EN
  localparam int NV = 5;
  logic [7:0] words [NV] = '{8'hA5, 8'h40, 8'h40, 8'h80, 8'h80};
  int         exps  [NV] = '{137, 121, 105, 105, 96};
  localparam logic [7:0] POST_WORD = 8'hA5;
  localparam int         POST_EXP  = 137;
`else
  localparam int NV = 11;
  logic [7:0] words [NV] = '{8'hA5, 8'h05, 8'hFF, 8'h10, 8'hEF, 8'h0F, 8'hF0,
                             8'h20, 8'hE0, 8'h20, 8'hE0};
  int         exps  [NV] = '{165, 16, 239, 16, 239, 16, 239, 32, 224, 32, 224};
  localparam logic [7:0] POST_WORD = 8'h5A;
  localparam int         POST_EXP  = 90;
`endif

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst:cs_n", int'(adc_cs_n), 1);
    chk("rst:sclk", int'(adc_sclk), 0);
    chk("rst:valid", int'(valid), 0);
    chk("rst:y", int'(y_p_mid), 128);
    reset = 1'b1;
    for (int i = 0; i < NV; i++)
      run_frame($sformatf("f%0d", i), words[i], exps[i], i != 0);
    abort_frame(8'hC3);
    run_frame("post_abort", POST_WORD, POST_EXP, 1'b0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
